// File: rtl/img_mem_scheduler.sv
// Shares one single-port image RAM between a line-prefetch burst and a filter requester.
// Latency: line-buffer write 2 cycles after i_line_start, filter read data 1 cycle after grant.
// Backpressure: filter holds f_req until f_gnt; IMG_SCHED_STARVE_GUARD_EN lets it steal burst slots.
module img_mem_scheduler #(
    parameter int IMG_W    = 225,
    parameter int IMG_H    = 225,
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          i_line_start,
    input  logic [11:0]   i_line_idx,
    output logic          o_busy,
    output logic          o_overrun,
    output logic          o_lb_we,
    output logic [11:0]   o_lb_addr,
    output logic [DW-1:0] o_lb_data,
    input  logic          f_req,
    input  logic          f_we,
    input  logic [AW-1:0] f_addr,
    input  logic [DW-1:0] f_wdata,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    localparam logic [11:0]   IMG_H_L  = 12'(IMG_H);
    localparam logic [11:0]   LAST_COL = 12'(IMG_W - 1);
    localparam logic [AW-1:0] IMG_W_A  = AW'(IMG_W);

    if (IMG_W * IMG_H > 2**AW || MAX_WAIT < 1) begin : g_bad_cfg
        $error("img_mem_scheduler: image does not fit AW or MAX_WAIT < 1");
    end

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [11:0]   col_q, col_d;
    logic          pf_rd_q;
    logic [11:0]   pf_col_q;
    logic          f_rd_q;
    logic          overrun_q;
    logic          start_ok;
    logic          pf_issue;
    logic          steal;
    logic [AW-1:0] idx_ext;

    assign idx_ext  = AW'(i_line_idx);
    assign start_ok = i_line_start && (i_line_idx < IMG_H_L);
    assign o_busy   = (state_q != IDLE);

`ifdef IMG_SCHED_STARVE_GUARD_EN
    localparam int            WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);
    logic [WW-1:0] wait_q;

    // Saturating count of consecutive ungranted request cycles.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (!f_req || f_gnt) begin
            wait_q <= '0;
        end else if (wait_q != WAIT_LIM) begin
            wait_q <= wait_q + WW'(1);
        end
    end

    assign steal = (state_q == BURST) && f_req && (wait_q == WAIT_LIM);
`else
    assign steal = 1'b0;
`endif

    assign pf_issue = (state_q == BURST) && !steal;
    assign f_gnt    = f_req && ((state_q != BURST) || steal);

    // A valid line start always (re)starts the burst, even mid-burst.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        col_d   = col_q;
        if (start_ok) begin
            state_d = BURST;
            base_d  = idx_ext * IMG_W_A;
            col_d   = '0;
        end else begin
            case (state_q)
                BURST: begin
                    if (pf_issue) begin
                        if (col_q == LAST_COL) begin
                            state_d = DRAIN;
                        end else begin
                            col_d = col_q + 12'd1;
                        end
                    end
                end
                DRAIN:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (pf_issue) begin
            m_en   = 1'b1;
            m_addr = base_q + AW'(col_q);
        end else if (f_gnt) begin
            m_en    = 1'b1;
            m_we    = f_we;
            m_addr  = f_addr;
            m_wdata = f_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            col_q     <= '0;
            pf_rd_q   <= 1'b0;
            pf_col_q  <= '0;
            f_rd_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            col_q     <= col_d;
            pf_rd_q   <= pf_issue;
            f_rd_q    <= f_gnt && !f_we;
            overrun_q <= start_ok && o_busy;
            if (pf_issue) begin
                pf_col_q <= col_q;
            end
        end
    end

    assign o_overrun = overrun_q;
    assign o_lb_we   = pf_rd_q;
    assign o_lb_addr = pf_col_q;
    assign o_lb_data = pf_rd_q ? m_rdata : '0;
    assign f_rvalid  = f_rd_q;
    assign f_rdata   = f_rd_q ? m_rdata : '0;

endmodule

// File: tb/tb_img_mem_scheduler.sv
// Directed bench for img_mem_scheduler with a 1-cycle-latency RAM model (mem[a] = a[7:0] until written).
module tb_img_mem_scheduler;

    localparam int AW = 16;
    localparam int DW = 8;
`ifdef IMG_SCHED_STARVE_GUARD_EN
    localparam int EXP_WAIT = 8;
    localparam int EXP_GAPS = 1;
`else
    localparam int EXP_WAIT = 220;
    localparam int EXP_GAPS = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic          i_line_start;
    logic [11:0]   i_line_idx;
    logic          o_busy, o_overrun, o_lb_we;
    logic [11:0]   o_lb_addr;
    logic [DW-1:0] o_lb_data;
    logic          f_req, f_we;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_wdata;
    logic          f_gnt, f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    img_mem_scheduler dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .i_line_start(i_line_start), .i_line_idx(i_line_idx),
        .o_busy(o_busy), .o_overrun(o_overrun),
        .o_lb_we(o_lb_we), .o_lb_addr(o_lb_addr), .o_lb_data(o_lb_data),
        .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
        .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] mem [0:65535];
    bit         wr_flag [0:65535];

    always @(posedge clk_i) begin
        if (m_en) begin
            if (m_we) begin
                mem[m_addr]     <= m_wdata;
                wr_flag[m_addr] <= 1'b1;
            end else begin
                m_rdata <= wr_flag[m_addr] ? mem[m_addr] : m_addr[7:0];
            end
        end
    end

    int         cyc_n = 0;
    int         lb_cnt = 0;
    int         busy_cnt = 0;
    int         ov_cnt = 0;
    logic [11:0] addr_log [0:4095];
    logic [7:0]  data_log [0:4095];
    int          cyc_log  [0:4095];

    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    always @(negedge clk_i) begin
        if (o_lb_we === 1'b1) begin
            addr_log[lb_cnt] <= o_lb_addr;
            data_log[lb_cnt] <= o_lb_data;
            cyc_log[lb_cnt]  <= cyc_n;
            lb_cnt           <= lb_cnt + 1;
        end
        if (o_busy === 1'b1)    busy_cnt <= busy_cnt + 1;
        if (o_overrun === 1'b1) ov_cnt   <= ov_cnt + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Errors in a logged run of IMG_W writes of the row starting at pixel `base`.
    function automatic int row_errs(input int s, input int base);
        int e = 0;
        for (int i = 0; i < 225; i++) begin
            if (addr_log[s + i] !== 12'(i) || data_log[s + i] !== 8'(base + i)) e++;
        end
        return e;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy === 1'b1 && n < 600) begin
            cyc();
            n++;
        end
        check(tag, o_busy, 1'b0);
        cyc();
        cyc();
    endtask

    initial begin
        int s, p, so, sb, n, gaps;
        rst_n = 1'b0; i_line_start = 1'b0; i_line_idx = '0;
        f_req = 1'b0; f_we = 1'b0; f_addr = '0; f_wdata = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_outputs", {o_busy, o_overrun, o_lb_we, o_lb_addr, o_lb_data, f_rvalid, f_rdata, m_en, m_addr}, '0);
        rst_n = 1'b1;
        cyc();

        // Plain burst of row 3.
        cyc();
        i_line_start = 1'b1; i_line_idx = 12'd3;
        s = lb_cnt; sb = busy_cnt; p = cyc_n;
        cyc();
        i_line_start = 1'b0;
        #1;
        check("t1_busy_rise", o_busy, 1'b1);
        check("t1_no_we_yet", o_lb_we, 1'b0);
        repeat (240) cyc();
        check("t1_idle", o_busy, 1'b0);
        check("t1_we_count", lb_cnt - s, 225);
        check("t1_busy_cycles", busy_cnt - sb, 226);
        check("t1_first_lat", cyc_log[s] - p, 2);
        check("t1_first_data", data_log[s], 8'hA3);
        check("t1_last_addr", addr_log[s + 224], 12'd224);
        check("t1_last_data", data_log[s + 224], 8'h83);
        check("t1_row_errs", row_errs(s, 675), 0);
        check("t1_contiguous", cyc_log[s + 224] - cyc_log[s], 224);

        // Filter write then read in IDLE.
        f_req = 1'b1; f_we = 1'b1; f_addr = 16'd100; f_wdata = 8'h5A;
        #1;
        check("t2_wr_gnt", f_gnt, 1'b1);
        check("t2_wr_ram", {m_en, m_we, m_addr, m_wdata}, {1'b1, 1'b1, 16'd100, 8'h5A});
        cyc();
        f_we = 1'b0;
        #1;
        check("t2_rd_gnt", f_gnt, 1'b1);
        check("t2_rd_ram", {m_en, m_we, m_addr}, {1'b1, 1'b0, 16'd100});
        check("t2_wr_no_rvalid", f_rvalid, 1'b0);
        cyc();
        f_req = 1'b0;
        #1;
        check("t2_rvalid", f_rvalid, 1'b1);
        check("t2_rdata", f_rdata, 8'h5A);
        cyc();
        check("t2_rvalid_drop", f_rvalid, 1'b0);

        // Filter request held from burst cycle 5.
        cyc();
        i_line_start = 1'b1; i_line_idx = 12'd3;
        s = lb_cnt; p = cyc_n;
        cyc();
        i_line_start = 1'b0;
        repeat (5) cyc();
        f_req = 1'b1; f_we = 1'b0; f_addr = 16'd7;
        #1;
        n = 0;
        while (f_gnt !== 1'b1 && n < 400) begin
            cyc();
            #1;
            n++;
        end
        check("t3_wait_cycles", n, EXP_WAIT);
        check("t3_gnt_busy", o_busy, 1'b1);
        cyc();
        f_req = 1'b0;
        #1;
        check("t3_rvalid", f_rvalid, 1'b1);
        check("t3_rdata", f_rdata, 8'h07);
        wait_idle("t3_idle");
        check("t3_we_count", lb_cnt - s, 225);
        check("t3_row_errs", row_errs(s, 675), 0);
        gaps = 0;
        for (int i = 0; i < 224; i++) begin
            if (cyc_log[s + i + 1] - cyc_log[s + i] != 1) gaps++;
        end
        check("t3_gaps", gaps, EXP_GAPS);

        // Overrun: row 4 requested at burst cycle 50.
        cyc();
        i_line_start = 1'b1; i_line_idx = 12'd3;
        s = lb_cnt; so = ov_cnt; p = cyc_n;
        cyc();
        i_line_start = 1'b0;
        repeat (50) cyc();
        i_line_start = 1'b1; i_line_idx = 12'd4;
        cyc();
        i_line_start = 1'b0;
        #1;
        check("t4_overrun", o_overrun, 1'b1);
        cyc();
        check("t4_overrun_1cyc", o_overrun, 1'b0);
        wait_idle("t4_idle");
        check("t4_ov_count", ov_cnt - so, 1);
        check("t4_we_count", lb_cnt - s, 276);
        check("t4_pending", {addr_log[s + 50], data_log[s + 50]}, {12'd50, 8'hD5});
        check("t4_restart", {addr_log[s + 51], data_log[s + 51]}, {12'd0, 8'h84});
        check("t4_restart_cyc", cyc_log[s + 51] - p, 53);
        check("t4_last", {addr_log[s + 275], data_log[s + 275]}, {12'd224, 8'h64});
        check("t4_row_errs", row_errs(s + 51, 900), 0);

        // Last row with a simultaneous filter read.
        cyc();
        i_line_start = 1'b1; i_line_idx = 12'd224;
        f_req = 1'b1; f_we = 1'b0; f_addr = 16'd7;
        s = lb_cnt; p = cyc_n;
        #1;
        check("t5_sim_gnt", f_gnt, 1'b1);
        check("t5_sim_ram", {m_en, m_we, m_addr}, {1'b1, 1'b0, 16'd7});
        cyc();
        i_line_start = 1'b0; f_req = 1'b0;
        #1;
        check("t5_rvalid", {f_rvalid, f_rdata}, {1'b1, 8'h07});
        check("t5_busy", o_busy, 1'b1);
        wait_idle("t5_idle");
        check("t5_first_lat", cyc_log[s] - p, 2);
        check("t5_first_data", data_log[s], 8'hE0);
        check("t5_last_data", data_log[s + 224], 8'hC0);
        check("t5_row_errs", row_errs(s, 50400), 0);

        // Out-of-range rows are ignored.
        for (int k = 0; k < 2; k++) begin
            cyc();
            i_line_start = 1'b1; i_line_idx = (k == 0) ? 12'd300 : 12'd225;
            s = lb_cnt; so = ov_cnt;
            cyc();
            i_line_start = 1'b0;
            #1;
            check("t6_no_busy", o_busy, 1'b0);
            repeat (4) cyc();
            check("t6_no_we", lb_cnt - s, 0);
            check("t6_no_overrun", ov_cnt - so, 0);
        end

        // Reset in the middle of a burst.
        cyc();
        i_line_start = 1'b1; i_line_idx = 12'd3;
        cyc();
        i_line_start = 1'b0;
        repeat (20) cyc();
        check("t7_we_before", o_lb_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t7_rst_outputs", {o_busy, o_overrun, o_lb_we, o_lb_addr, o_lb_data, f_gnt, f_rvalid, f_rdata,
                                 m_en, m_we, m_addr, m_wdata}, '0);
        cyc();
        cyc();
        rst_n = 1'b1;
        s = lb_cnt;
        repeat (20) cyc();
        check("t7_no_we_after", lb_cnt - s, 0);
        check("t7_idle_after", o_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/img_mem_scheduler.md
Name: img_mem_scheduler

Overview:
- Shares one single-port image RAM between two requesters: a display line-prefetch engine and a filter engine.
- On each line-start pulse it streams one image row of IMG_W pixels from RAM into the display line buffer.
- Filter read/write requests are served in every cycle the prefetch burst does not use the RAM.
- Sits between the pixel loader path and the filter datapath, in the sys_clk domain, ahead of the DVI TX.

Parameters:
- IMG_W, 225, pixels per image row; burst length.
- IMG_H, 225, image rows; valid range of i_line_idx.
- AW, 16, RAM word address width; must satisfy IMG_W*IMG_H <= 2^AW.
- DW, 8, pixel/RAM data width.
- MAX_WAIT, 8, filter starvation limit in cycles; used only with IMG_SCHED_STARVE_GUARD_EN.

Ports:
- clk_i  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_line_start  in  1  one-cycle pulse requesting prefetch of row i_line_idx.
- i_line_idx  in  12  row number, sampled with i_line_start.
- o_busy  out  1  high while a burst is issuing or draining.
- o_overrun  out  1  one-cycle pulse: i_line_start arrived while o_busy was high.
- o_lb_we  out  1  line-buffer write strobe.
- o_lb_addr  out  12  line-buffer column, 0..IMG_W-1.
- o_lb_data  out  DW  pixel written to the line buffer.
- f_req  in  1  filter request, held until granted.
- f_we  in  1  filter write (1) or read (0).
- f_addr  in  AW  filter RAM address.
- f_wdata  in  DW  filter write data.
- f_gnt  out  1  filter request accepted this cycle (combinational).
- f_rvalid  out  1  filter read data valid, one cycle after a granted read.
- f_rdata  out  DW  filter read data.
- m_en  out  1  RAM enable.
- m_we  out  1  RAM write enable.
- m_addr  out  AW  RAM address.
- m_wdata  out  DW  RAM write data.
- m_rdata  in  DW  RAM read data; fixed 1-cycle latency after m_en with m_we=0.

Behaviour:
- Reset values: every output 0; FSM in IDLE; column counter 0.
- FSM IDLE:
  - i_line_start with i_line_idx < IMG_H: latch base = i_line_idx*IMG_W, set col = 0, go to BURST.
  - i_line_idx >= IMG_H: ignore the pulse; no burst, no overrun.
- FSM BURST:
  - Each cycle the prefetch owns the RAM, drive m_en=1, m_we=0, m_addr=base+col, then col++.
  - After issuing col = IMG_W-1, go to DRAIN.
- FSM DRAIN:
  - Lasts exactly one cycle so the last read data can return.
  - Then go to IDLE; o_busy falls on the IDLE cycle.
- Line-buffer write path:
  - A prefetch read issued at cycle t produces o_lb_we=1 at t+1.
  - At t+1, o_lb_addr = column issued at t and o_lb_data = m_rdata.
  - A stalled (stolen) cycle issues nothing, so no o_lb_we follows it.
- Arbitration:
  - In IDLE, f_req gets the RAM: f_gnt=1 in the same cycle, and m_en/m_we/m_addr/m_wdata mirror the f_* inputs.
  - In BURST, the prefetch has priority; f_gnt=0 unless the starvation guard fires.
  - In DRAIN, the RAM is free and a filter request is granted.
- Filter reads: a granted read gives f_rvalid=1 and f_rdata=m_rdata on the next cycle. A granted write gives no f_rvalid.
- Exactly one of {prefetch, filter} drives the RAM in any cycle. m_en=0 when neither does.
- Overrun: i_line_start while o_busy=1:
  - o_overrun pulses for one cycle.
  - The current burst is aborted; any pending read still returns and is written to the line buffer.
  - The new row is latched and the burst restarts at col=0 on the next cycle.
- Simultaneous i_line_start and f_req in IDLE: the filter is granted that cycle; the burst starts the next cycle.
- Address arithmetic: use AW-bit unsigned arithmetic; base+col never wraps within legal parameters.

Optional Feature:
- Macro IMG_SCHED_STARVE_GUARD_EN.
- With the macro defined:
  - A wait counter increments each cycle f_req=1 and f_gnt=0, and clears on grant.
  - When the counter reaches MAX_WAIT during BURST, the filter is granted that cycle and the prefetch stalls: col is held and no o_lb_we follows.
  - Each burst then takes at most IMG_W + ceil(IMG_W/MAX_WAIT) cycles.
- Without the macro: the filter waits for the whole burst; no counter logic is built.

Test Plan:
- Pulse i_line_start with i_line_idx=3, RAM preloaded mem[a]=a[7:0] -> 225 consecutive o_lb_we with addr 0..224 and data (675+col)[7:0]; o_busy high for 226 cycles; first o_lb_we 2 cycles after the pulse.
- In IDLE, filter write then read at addr 100 with data 0x5A -> f_gnt the same cycle for each; f_rvalid=1 with f_rdata=0x5A one cycle after the read grant.
- f_req held from cycle 5 of a burst, guard off -> f_gnt first asserted in DRAIN; no o_lb_we missing.
- Same as the previous case with IMG_SCHED_STARVE_GUARD_EN, MAX_WAIT=8 -> f_gnt after 8 waiting cycles; exactly one skipped issue slot; line-buffer contents still correct.
- Second i_line_start (idx=4) at burst cycle 50 -> o_overrun pulses once; next o_lb_addr sequence restarts at 0 with row-4 data.
- i_line_idx=300 -> no burst, no overrun, o_busy stays 0. Assert rst_n mid-burst -> all outputs 0 immediately; no o_lb_we after release.
